// File: rtl/sd4_pkg.sv
// Shared types and fp16 constants for the SD4 MAC array datapath blocks.
package sd4_pkg;
   localparam int FP16_W = 16;
   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
   localparam int FP16_SIGN = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/psum_accum_buf_mem.sv
// Partial-sum storage: one synchronous write port, two combinational read ports.
// The array is not reset; a pass-0 write always precedes any read of an entry.
module psum_mem
   import sd4_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [FP16_W-1:0] wd,
   input  logic [AW-1:0]     ra_acc,
   output logic [FP16_W-1:0] rd_acc,
   input  logic [AW-1:0]     ra_drn,
   output logic [FP16_W-1:0] rd_drn
);
   logic [FP16_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd_acc = mem[ra_acc];
   assign rd_drn = mem[ra_drn];
endmodule

// File: rtl/psum_accum_buf.sv
// Partial-sum accumulation buffer on the PE psum loop: feeds running sums,
// stores PE results for num_pass passes, then drains through optional ReLU.
module psum_accum_buf
   import sd4_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW:0]       num_pos,
   input  logic [3:0]        num_pass,
   input  logic              relu_en,
   input  logic              mac_valid,
   output logic [FP16_W-1:0] psum_to_pe,
   input  logic [FP16_W-1:0] psum_from_pe,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP16_W-1:0] out_data,
   output logic              busy,
   output logic              done
);
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   state_e            state;
   logic [AW:0]       cfg_pos;
   logic [3:0]        cfg_pass;
   logic              relu_q;
   logic [AW-1:0]     pos, rd;
   logic [3:0]        pass;
   logic [AW:0]       pos_clamp;
   logic              pos_last, pass_last, rd_last, we;
   logic [FP16_W-1:0] rd_acc, rd_drn;

   assign pos_clamp = (num_pos > DEPTH_V) ? DEPTH_V : num_pos;
   assign pos_last  = ({1'b0, pos} == cfg_pos - 1'b1);
   assign rd_last   = ({1'b0, rd} == cfg_pos - 1'b1);
   assign pass_last = (pass == cfg_pass - 4'd1);
   assign we        = (state == ST_ACCUM) && mac_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cfg_pos  <= '0;
         cfg_pass <= 4'd1;
         relu_q   <= 1'b0;
         pos      <= '0;
         pass     <= '0;
         rd       <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               cfg_pos  <= pos_clamp;
               cfg_pass <= (num_pass == 4'd0) ? 4'd1 : num_pass;
               relu_q   <= relu_en;
               pos      <= '0;
               pass     <= '0;
               rd       <= '0;
               state    <= (pos_clamp == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: if (mac_valid) begin
               if (pos_last) begin
                  pos  <= '0;
                  pass <= pass + 4'd1;
                  if (pass_last) begin
                     rd    <= '0;
                     state <= ST_DRAIN;
                  end
               end else begin
                  pos <= pos + 1'b1;
               end
            end
            ST_DRAIN: if (out_ready) begin
               rd <= rd + 1'b1;
               if (rd_last) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   psum_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk    (clk),
      .we     (we),
      .wa     (pos),
      .wd     (psum_from_pe),
      .ra_acc (pos),
      .rd_acc (rd_acc),
      .ra_drn (rd),
      .rd_drn (rd_drn)
   );

   // Sign-bit test only: negative zero drains as +0 under ReLU.
   assign psum_to_pe = (state == ST_ACCUM && pass != 4'd0) ? rd_acc : FP16_ZERO;
   assign out_valid  = (state == ST_DRAIN);
   assign out_data   = (state != ST_DRAIN) ? FP16_ZERO :
                       (relu_q && rd_drn[FP16_SIGN]) ? FP16_ZERO : rd_drn;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
endmodule

// File: tb/tb_psum_accum_buf.sv
// Directed-vector bench for psum_accum_buf; all tasks start and end on a negedge.
module tb_psum_accum_buf;
   logic        clk, rst, start, relu_en, mac_valid, out_valid, out_ready, busy, done;
   logic [6:0]  num_pos;
   logic [3:0]  num_pass;
   logic [15:0] psum_to_pe, psum_from_pe, out_data;
   int          n_vec = 0, n_err = 0;

   psum_accum_buf #(.DEPTH(64), .AW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .num_pos(num_pos), .num_pass(num_pass),
      .relu_en(relu_en), .mac_valid(mac_valid), .psum_to_pe(psum_to_pe),
      .psum_from_pe(psum_from_pe), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [6:0] p, input logic [3:0] n, input logic r);
      start = 1'b1; num_pos = p; num_pass = n; relu_en = r;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic acc(input logic [15:0] exp_to, input logic [15:0] from);
      chk("to_pe", psum_to_pe, exp_to);
      chk("busy_acc", 16'(busy), 16'd1);
      mac_valid = 1'b1; psum_from_pe = from;
      @(negedge clk);
      mac_valid = 1'b0;
   endtask

   // Behavioural PE: adds 1.0 to whatever the buffer currently drives.
   function automatic logic [15:0] pe_add1(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h3C00;
         16'h3C00: return 16'h4000;
         16'h4000: return 16'h4200;
         default:  return 16'hFFFF;
      endcase
   endfunction

   task automatic acc_pe(input logic [15:0] exp_to);
      acc(exp_to, pe_add1(psum_to_pe));
   endtask

   task automatic gap(input logic [15:0] exp_to);
      chk("to_pe_gap", psum_to_pe, exp_to);
      mac_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic drn(input logic rdy, input logic [15:0] exp_data);
      chk("out_valid", 16'(out_valid), 16'd1);
      chk("out_data", out_data, exp_data);
      chk("to_pe_drn", psum_to_pe, 16'h0000);
      out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic fin();
      out_ready = 1'b0;
      chk("done_hi", 16'(done), 16'd1);
      chk("out_valid_done", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("done_lo", 16'(done), 16'd0);
      chk("busy_lo", 16'(busy), 16'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; num_pos = '0; num_pass = '0; relu_en = 1'b0;
      mac_valid = 1'b0; out_ready = 1'b0; psum_from_pe = '0;
      #12;
      chk("rst_to_pe", psum_to_pe, 16'h0000);
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_flags", {12'd0, out_valid, busy, done, 1'b0}, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // single pass
      do_start(7'd4, 4'd1, 1'b0);
      acc(16'h0000, 16'h3C00); acc(16'h0000, 16'h4000);
      acc(16'h0000, 16'h4200); acc(16'h0000, 16'h4400);
      drn(1'b1, 16'h3C00); drn(1'b1, 16'h4000); drn(1'b1, 16'h4200); drn(1'b1, 16'h4400);
      fin();

      // three passes through the PE model
      do_start(7'd2, 4'd3, 1'b0);
      acc_pe(16'h0000); acc_pe(16'h0000); acc_pe(16'h3C00);
      acc_pe(16'h3C00); acc_pe(16'h4000); acc_pe(16'h4000);
      drn(1'b1, 16'h4200); drn(1'b1, 16'h4200);
      fin();

      // ReLU on, then off
      do_start(7'd3, 4'd1, 1'b1);
      acc(16'h0000, 16'hC000); acc(16'h0000, 16'h8000); acc(16'h0000, 16'h3C00);
      drn(1'b1, 16'h0000); drn(1'b1, 16'h0000); drn(1'b1, 16'h3C00);
      fin();
      do_start(7'd3, 4'd1, 1'b0);
      acc(16'h0000, 16'hC000); acc(16'h0000, 16'h8000); acc(16'h0000, 16'h3C00);
      drn(1'b1, 16'hC000); drn(1'b1, 16'h8000); drn(1'b1, 16'h3C00);
      fin();

      // mac_valid gaps and drain backpressure
      do_start(7'd3, 4'd2, 1'b0);
      acc(16'h0000, 16'h1111); gap(16'h0000); acc(16'h0000, 16'h2222);
      gap(16'h0000); gap(16'h0000); acc(16'h0000, 16'h3333);
      acc(16'h1111, 16'h1112); gap(16'h2222); acc(16'h2222, 16'h2223);
      gap(16'h3333); acc(16'h3333, 16'h3334);
      drn(1'b1, 16'h1112); drn(1'b0, 16'h2223); drn(1'b0, 16'h2223);
      drn(1'b1, 16'h2223); drn(1'b1, 16'h3334);
      fin();

      // empty tile
      do_start(7'd0, 4'd1, 1'b0);
      chk("empty_done", 16'(done), 16'd1);
      chk("empty_valid", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("empty_idle", {14'd0, busy, out_valid}, 16'h0000);

      // num_pass=0 acts as one pass
      do_start(7'd2, 4'd0, 1'b0);
      acc(16'h0000, 16'h5000); acc(16'h0000, 16'h5100);
      drn(1'b1, 16'h5000); drn(1'b1, 16'h5100);
      fin();

      // num_pos clamps to DEPTH
      do_start(7'd69, 4'd1, 1'b0);
      for (int i = 0; i < 64; i++) acc(16'h0000, 16'h0100 + 16'(i));
      for (int i = 0; i < 64; i++) drn(1'b1, 16'h0100 + 16'(i));
      fin();

      // start during DRAIN is ignored
      do_start(7'd2, 4'd1, 1'b0);
      acc(16'h0000, 16'h1234); acc(16'h0000, 16'h5678);
      start = 1'b1; num_pos = 7'd4;
      drn(1'b0, 16'h1234);
      start = 1'b0;
      drn(1'b1, 16'h1234); drn(1'b1, 16'h5678);
      fin();

      // async reset mid-ACCUM
      do_start(7'd2, 4'd2, 1'b0);
      acc(16'h0000, 16'hAAAA); acc(16'h0000, 16'hBBBB);
      chk("pre_rst_to_pe", psum_to_pe, 16'hAAAA);
      mac_valid = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_async_to_pe", psum_to_pe, 16'h0000);
      chk("rst_async_busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mac_valid = 1'b0;
      chk("post_rst_idle", {13'd0, busy, out_valid, done}, 16'h0000);
      chk("post_rst_to_pe", psum_to_pe, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/psum_accum_buf.md
# psum_accum_buf

Partial-sum accumulation buffer for the SD4 MAC array. It sits on the `psum`/`psum_out` loop of a PE column:
- It feeds each output position's running fp16 partial sum into the PE's `psum` input.
- It writes the PE's `psum_out` back for that position.
- It repeats this for a programmed number of channel passes.
- When all passes finish, it drains the final sums through an optional ReLU on a valid/ready stream.

## Interface
Parameters:
- `DEPTH`, 64: output positions per tile (buffer entries).
- `AW`, 6: address width, clog2(`DEPTH`).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins a tile. Honoured only in IDLE.
- `num_pos`, in, `AW`+1: positions per pass. Latched on `start`.
- `num_pass`, in, 4: channel passes. Latched on `start`.
- `relu_en`, in, 1: enables ReLU on drain. Latched on `start`.
- `mac_valid`, in, 1: the PE's registered MAC result is valid this cycle.
- `psum_to_pe`, out, 16: fp16 value driven to the PE `psum` input.
- `psum_from_pe`, in, 16: fp16 value from the PE `psum_out`.
- `out_valid`, out, 1: drain data valid.
- `out_ready`, in, 1: downstream accepts drain data.
- `out_data`, out, 16: fp16 drained sum.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse at tile completion.

## Operation
States: IDLE, ACCUM, DRAIN, DONE.

Latched configuration on `start`:
- `num_pass`=0 is treated as 1.
- `num_pos`=0 gives an empty tile.
- `num_pos` greater than `DEPTH` is clamped to `DEPTH`.

IDLE:
- On `start` with a non-empty tile: clear `pos` and `pass`, go to ACCUM.
- On `start` with an empty tile: go to DONE.
- `mac_valid`, `out_ready` and a `start` arriving in any other state are ignored.

ACCUM:
- `psum_to_pe` = 16'h0000 when `pass`==0, otherwise `mem[pos]`. Both paths are combinational.
- On each cycle with `mac_valid`=1:
  - `mem[pos]` <= `psum_from_pe`.
  - `pos` increments.
  - When `pos`==`num_pos`-1, `pos` wraps to 0 and `pass` increments.
- When `mac_valid`=1 at `pos`==`num_pos`-1 and `pass`==`num_pass`-1, the state goes to DRAIN and the read pointer `rd` is set to 0.
- A cycle with `mac_valid`=0 leaves `mem`, `pos` and `pass` unchanged. The PE stall is tolerated.

DRAIN:
- `out_valid`=1.
- `out_data` = 16'h0000 when `relu_en`=1 and `mem[rd][15]`=1; otherwise `out_data` = `mem[rd]`. Negative zero therefore maps to +0.
- On `out_valid`&&`out_ready`, `rd` increments.
- The handshake at `rd`==`num_pos`-1 moves the state to DONE.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.

DONE:
- `done`=1 for exactly one cycle, then the state returns to IDLE.

General rules:
- The block performs no fp16 arithmetic. The PE performs all addition. Values are stored bit-exact.
- `psum_to_pe`=0 in every state except ACCUM.
- Reset mid-operation aborts the tile immediately. `mem` contents are then undefined; they are not reset. A pass-0 write always precedes any read, so this is safe.

## Timing
Reset values: state IDLE, `pos`=`pass`=`rd`=0, `psum_to_pe`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.

Cycle-level behaviour:
- `start` in cycle t: ACCUM from t+1, `busy`=1 from t+1.
- Read-modify-write per position completes in one cycle. The PE output `psum_from_pe` for `psum_to_pe` is sampled at the same clock edge; the PE adder path is combinational.
- Last accumulate in cycle t: `out_valid`=1 from t+1.
- Drain throughput is one word per cycle while `out_ready`=1.
- Final handshake in cycle t: `done`=1 in t+1, `busy`=0 in t+2.
- Empty tile: `start` at t, `done` at t+1, no drain output.
- Minimum tile length is `num_pos`·`num_pass` accumulate cycles + `num_pos` drain cycles + 2.

## Structure
- Shared package `sd4_pkg`:
  - state enum (IDLE/ACCUM/DRAIN/DONE);
  - `FP16_W`=16;
  - `FP16_ZERO`=16'h0000;
  - `FP16_SIGN`=15.
- Sub-module `psum_mem`:
  - `DEPTH`×16 register array;
  - one synchronous write port;
  - two combinational read ports, one for accumulate and one for drain;
  - no reset on the array.
- The FSM, counters and ReLU mux live in `psum_accum_buf`.

## Test plan
1. Single pass, `num_pos`=4:
   - Stimulus: `psum_from_pe` = 3C00, 4000, 4200, 4400 with `mac_valid` held high.
   - Required response: `psum_to_pe`=0000 on all four cycles; the drain emits 3C00, 4000, 4200, 4400; `done` one cycle after the last handshake.
2. Three passes, `num_pos`=2, with a behavioural PE model that adds 1.0 per pass:
   - Required response: `psum_to_pe` sequence 0000, 0000, 3C00, 3C00, 4000, 4000; drain emits 4200, 4200.
3. ReLU:
   - Stimulus: stored C000, 8000, 3C00 with `relu_en`=1.
   - Required response: drain emits 0000, 0000, 3C00.
   - With `relu_en`=0, the stored values pass through unchanged.
4. Backpressure:
   - Stimulus: `out_ready` toggles 1,0,0,1 during the drain; `mac_valid` has gaps in ACCUM.
   - Required response: no lost or duplicated words; `out_data` stable while stalled; `pos` frozen on gaps.
5. Corner cases:
   - `num_pos`=0: `done` at t+1, `out_valid` never asserted.
   - `num_pass`=0 behaves exactly as 1.
   - `num_pos`=DEPTH+5 clamps to 64 entries.
6. Reset and ignored inputs:
   - Asserting `rst` mid-ACCUM drops all outputs to 0 asynchronously; the block is IDLE after release.
   - A `start` arriving in DRAIN is ignored.
